// File: rtl/k_means_pkg.sv
// k_means_pkg
// Shared types and widths for the k-means iteration scheduler:
//   X_W / Y_W  : centroid coordinate widths (pixel column / row)
//   D_W        : Manhattan distance width, wide enough for |dx|+|dy| without overflow
//   point_t    : one centroid position
//   km_state_e : scheduler FSM states
package k_means_pkg;

  localparam int X_W = 11;
  localparam int Y_W = 10;
  localparam int D_W = 12;

  typedef struct packed {
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
  } point_t;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_FRAME = 3'd1,
    ST_ACCUM      = 3'd2,
    ST_TABULATE   = 3'd3,
    ST_WAIT_DIV   = 3'd4,
    ST_UPDATE     = 3'd5,
    ST_DONE       = 3'd6
  } km_state_e;

endpackage

// File: rtl/km_manhattan.sv
// km_manhattan
// Purely combinational Manhattan distance between two points.
//   a_x_i, a_y_i : first point
//   b_x_i, b_y_i : second point
//   d_o          : |ax-bx| + |ay-by|, unsigned
module km_manhattan
  import k_means_pkg::*;
(
  input  logic [X_W-1:0] a_x_i,
  input  logic [Y_W-1:0] a_y_i,
  input  logic [X_W-1:0] b_x_i,
  input  logic [Y_W-1:0] b_y_i,
  output logic [D_W-1:0] d_o
);

  logic [X_W-1:0] dx_s;
  logic [Y_W-1:0] dy_s;

  // Absolute differences are formed by subtracting the smaller from the larger,
  // so no signed arithmetic is needed.
  always_comb begin
    if (a_x_i >= b_x_i) begin
      dx_s = a_x_i - b_x_i;
    end else begin
      dx_s = b_x_i - a_x_i;
    end
    if (a_y_i >= b_y_i) begin
      dy_s = a_y_i - b_y_i;
    end else begin
      dy_s = b_y_i - a_y_i;
    end
    d_o = {1'b0, dx_s} + {2'b00, dy_s};
  end

endmodule

// File: rtl/k_means_scheduler.sv
// k_means_scheduler
// Sequences k-means refinement iterations around an external pixel clusterer:
// gate one frame of pixels into it, pulse tabulate, wait for new centroids,
// then decide whether to iterate again, stop on convergence or stop at MAX_ITER.
// Ports:
//   clk_in, rst_n_in          : clock, async active-low reset
//   start_in, abort_in        : run control pulses
//   frame_start_in/_end_in    : frame boundary strobes
//   pixel_gate_out            : high while a frame is being accumulated
//   tabulate_out              : one-cycle pulse starting the clusterer dividers
//   km_valid_in, km_*_in      : new centroids from the clusterer
//   cent_*_out                : current centroids fed to the clusterer
//   iter_out                  : completed iterations in this run
//   busy_out, result_valid_out, converged_out, timeout_out : status
module k_means_scheduler
  import k_means_pkg::*;
#(
  parameter int             MAX_ITER    = 8,
  parameter int             CONV_THRESH = 2,
  parameter int             DIV_TIMEOUT = 64,
  parameter int             CONTINUOUS  = 0,
  parameter logic [X_W-1:0] SEED_A_X    = 11'd160,
  parameter logic [Y_W-1:0] SEED_A_Y    = 10'd360,
  parameter logic [X_W-1:0] SEED_B_X    = 11'd640,
  parameter logic [Y_W-1:0] SEED_B_Y    = 10'd360,
  parameter logic [X_W-1:0] SEED_C_X    = 11'd1120,
  parameter logic [Y_W-1:0] SEED_C_Y    = 10'd360
) (
  input  logic           clk_in,
  input  logic           rst_n_in,
  input  logic           start_in,
  input  logic           abort_in,
  input  logic           frame_start_in,
  input  logic           frame_end_in,
  output logic           pixel_gate_out,
  output logic           tabulate_out,
  input  logic           km_valid_in,
  input  logic [X_W-1:0] km_a_x_in,
  input  logic [Y_W-1:0] km_a_y_in,
  input  logic [X_W-1:0] km_b_x_in,
  input  logic [Y_W-1:0] km_b_y_in,
  input  logic [X_W-1:0] km_c_x_in,
  input  logic [Y_W-1:0] km_c_y_in,
  output logic [X_W-1:0] cent_a_x_out,
  output logic [Y_W-1:0] cent_a_y_out,
  output logic [X_W-1:0] cent_b_x_out,
  output logic [Y_W-1:0] cent_b_y_out,
  output logic [X_W-1:0] cent_c_x_out,
  output logic [Y_W-1:0] cent_c_y_out,
  output logic [7:0]     iter_out,
  output logic           busy_out,
  output logic           result_valid_out,
  output logic           converged_out,
  output logic           timeout_out
);

  localparam point_t         SEED_A    = '{x: SEED_A_X, y: SEED_A_Y};
  localparam point_t         SEED_B    = '{x: SEED_B_X, y: SEED_B_Y};
  localparam point_t         SEED_C    = '{x: SEED_C_X, y: SEED_C_Y};
  localparam logic [15:0]    DIV_LAST  = 16'(DIV_TIMEOUT - 1);
  localparam logic [7:0]     ITER_LAST = 8'(MAX_ITER);
  localparam logic [D_W-1:0] THRESH    = D_W'(CONV_THRESH);

  km_state_e      state_q, state_d;
  point_t         cent_q [3];
  point_t         cent_d [3];
  point_t         cap_q  [3];
  point_t         cap_d  [3];
  logic [7:0]     iter_q, iter_d;
  logic [15:0]    cnt_q, cnt_d;
  logic           conv_q, conv_d;
  logic           tmo_q, tmo_d;
  logic           gate_q, tab_q, busy_q, rv_q;
  logic [D_W-1:0] d_a_s, d_b_s, d_c_s;
  logic           settled_s;

  // Distance of each captured centroid from the one currently in use.
  km_manhattan u_dist_a (
    .a_x_i(cap_q[0].x), .a_y_i(cap_q[0].y),
    .b_x_i(cent_q[0].x), .b_y_i(cent_q[0].y), .d_o(d_a_s)
  );
  km_manhattan u_dist_b (
    .a_x_i(cap_q[1].x), .a_y_i(cap_q[1].y),
    .b_x_i(cent_q[1].x), .b_y_i(cent_q[1].y), .d_o(d_b_s)
  );
  km_manhattan u_dist_c (
    .a_x_i(cap_q[2].x), .a_y_i(cap_q[2].y),
    .b_x_i(cent_q[2].x), .b_y_i(cent_q[2].y), .d_o(d_c_s)
  );

  assign settled_s = (d_a_s <= THRESH) && (d_b_s <= THRESH) && (d_c_s <= THRESH);

  // Next-state and datapath update; abort overrides every other event.
  always_comb begin
    state_d = state_q;
    cent_d  = cent_q;
    cap_d   = cap_q;
    iter_d  = iter_q;
    cnt_d   = cnt_q;
    conv_d  = conv_q;
    tmo_d   = tmo_q;
    if (abort_in && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_in) begin
            cent_d[0] = SEED_A;
            cent_d[1] = SEED_B;
            cent_d[2] = SEED_C;
            iter_d    = 8'd0;
            conv_d    = 1'b0;
            tmo_d     = 1'b0;
            state_d   = ST_WAIT_FRAME;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_WAIT_FRAME: begin
          if (frame_start_in) begin
            state_d = ST_ACCUM;
          end else begin
            state_d = ST_WAIT_FRAME;
          end
        end
        ST_ACCUM: begin
          if (frame_end_in) begin
            state_d = ST_TABULATE;
          end else begin
            state_d = ST_ACCUM;
          end
        end
        ST_TABULATE: begin
          cnt_d   = 16'd0;
          state_d = ST_WAIT_DIV;
        end
        ST_WAIT_DIV: begin
          // A result arriving on the final allowed cycle still wins over the timeout.
          if (km_valid_in) begin
            cap_d[0] = '{x: km_a_x_in, y: km_a_y_in};
            cap_d[1] = '{x: km_b_x_in, y: km_b_y_in};
            cap_d[2] = '{x: km_c_x_in, y: km_c_y_in};
            state_d  = ST_UPDATE;
          end else if (cnt_q == DIV_LAST) begin
            tmo_d   = 1'b1;
            conv_d  = 1'b0;
            state_d = ST_DONE;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        ST_UPDATE: begin
          cent_d = cap_q;
          iter_d = iter_q + 8'd1;
          if (settled_s) begin
            conv_d  = 1'b1;
            state_d = ST_DONE;
          end else if ((iter_q + 8'd1) == ITER_LAST) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_WAIT_FRAME;
          end
        end
        ST_DONE: begin
          if (CONTINUOUS != 0) begin
            iter_d  = 8'd0;
            state_d = ST_WAIT_FRAME;
          end else begin
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State and datapath registers; status outputs are registered from the next state
  // so each one lines up exactly with the state it describes.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= ST_IDLE;
      cent_q  <= '{SEED_A, SEED_B, SEED_C};
      cap_q   <= '{SEED_A, SEED_B, SEED_C};
      iter_q  <= 8'd0;
      cnt_q   <= 16'd0;
      conv_q  <= 1'b0;
      tmo_q   <= 1'b0;
      gate_q  <= 1'b0;
      tab_q   <= 1'b0;
      busy_q  <= 1'b0;
      rv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cent_q  <= cent_d;
      cap_q   <= cap_d;
      iter_q  <= iter_d;
      cnt_q   <= cnt_d;
      conv_q  <= conv_d;
      tmo_q   <= tmo_d;
      gate_q  <= (state_d == ST_ACCUM);
      tab_q   <= (state_d == ST_TABULATE);
      busy_q  <= (state_d != ST_IDLE);
      rv_q    <= (state_d == ST_DONE);
    end
  end

  assign pixel_gate_out   = gate_q;
  assign tabulate_out     = tab_q;
  assign busy_out         = busy_q;
  assign result_valid_out = rv_q;
  assign converged_out    = conv_q;
  assign timeout_out      = tmo_q;
  assign iter_out         = iter_q;
  assign cent_a_x_out     = cent_q[0].x;
  assign cent_a_y_out     = cent_q[0].y;
  assign cent_b_x_out     = cent_q[1].x;
  assign cent_b_y_out     = cent_q[1].y;
  assign cent_c_x_out     = cent_q[2].x;
  assign cent_c_y_out     = cent_q[2].y;

endmodule

// File: tb/tb_k_means_scheduler.sv
// tb_k_means_scheduler
// Directed bench for k_means_scheduler. Stimulus tasks keep a transaction-level
// model of what every output must be (centroids, iteration count, flags, pulses);
// a negedge process compares the DUT against that model every cycle, and a few
// literal checks pin the model to hand-computed values.
module tb_k_means_scheduler;

  logic        clk_in = 1'b0;
  logic        rst_n_in = 1'b0;
  logic        start_in = 1'b0, abort_in = 1'b0;
  logic        frame_start_in = 1'b0, frame_end_in = 1'b0;
  logic        km_valid_in = 1'b0;
  logic [10:0] km_a_x_in = 11'd0, km_b_x_in = 11'd0, km_c_x_in = 11'd0;
  logic [9:0]  km_a_y_in = 10'd0, km_b_y_in = 10'd0, km_c_y_in = 10'd0;
  logic        pixel_gate_out, tabulate_out, busy_out, result_valid_out;
  logic        converged_out, timeout_out;
  logic [10:0] cent_a_x_out, cent_b_x_out, cent_c_x_out;
  logic [9:0]  cent_a_y_out, cent_b_y_out, cent_c_y_out;
  logic [7:0]  iter_out;

  k_means_scheduler dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .start_in(start_in), .abort_in(abort_in),
    .frame_start_in(frame_start_in), .frame_end_in(frame_end_in),
    .pixel_gate_out(pixel_gate_out), .tabulate_out(tabulate_out),
    .km_valid_in(km_valid_in),
    .km_a_x_in(km_a_x_in), .km_a_y_in(km_a_y_in),
    .km_b_x_in(km_b_x_in), .km_b_y_in(km_b_y_in),
    .km_c_x_in(km_c_x_in), .km_c_y_in(km_c_y_in),
    .cent_a_x_out(cent_a_x_out), .cent_a_y_out(cent_a_y_out),
    .cent_b_x_out(cent_b_x_out), .cent_b_y_out(cent_b_y_out),
    .cent_c_x_out(cent_c_x_out), .cent_c_y_out(cent_c_y_out),
    .iter_out(iter_out), .busy_out(busy_out), .result_valid_out(result_valid_out),
    .converged_out(converged_out), .timeout_out(timeout_out)
  );

  always #5 clk_in = ~clk_in;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // model of the outputs
  int exp_x [3];
  int exp_y [3];
  int exp_iter;
  bit exp_conv, exp_tmo, exp_busy, exp_gate, exp_tab, exp_rv;
  int seed_x [3] = '{160, 640, 1120};
  int seed_y [3] = '{360, 360, 360};

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic int mdist(input int ax, input int ay, input int bx, input int by);
    return ((ax > bx) ? ax - bx : bx - ax) + ((ay > by) ? ay - by : by - ay);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      exp_x[i] = seed_x[i];
      exp_y[i] = seed_y[i];
    end
    exp_iter = 0;
    {exp_conv, exp_tmo, exp_busy, exp_gate, exp_tab, exp_rv} = 6'b000000;
  endtask

  // every-cycle comparison against the model
  always @(negedge clk_in) begin
    if (chk_en) begin
      check("cent_a_x", int'(cent_a_x_out), exp_x[0]);
      check("cent_a_y", int'(cent_a_y_out), exp_y[0]);
      check("cent_b_x", int'(cent_b_x_out), exp_x[1]);
      check("cent_b_y", int'(cent_b_y_out), exp_y[1]);
      check("cent_c_x", int'(cent_c_x_out), exp_x[2]);
      check("cent_c_y", int'(cent_c_y_out), exp_y[2]);
      check("iter", int'(iter_out), exp_iter);
      check("busy", int'(busy_out), int'(exp_busy));
      check("gate", int'(pixel_gate_out), int'(exp_gate));
      check("tabulate", int'(tabulate_out), int'(exp_tab));
      check("result_valid", int'(result_valid_out), int'(exp_rv));
      check("converged", int'(converged_out), int'(exp_conv));
      check("timeout", int'(timeout_out), int'(exp_tmo));
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_start();
    start_in = 1'b1;
    tick();
    start_in = 1'b0;
    model_reset();
    exp_busy = 1'b1;
  endtask

  // one frame: start strobe, a few pixel cycles, end strobe, tabulate; ends in WAIT_DIV
  task automatic do_frame();
    frame_start_in = 1'b1;
    tick();
    frame_start_in = 1'b0;
    exp_gate = 1'b1;
    repeat (3) tick();
    frame_end_in = 1'b1;
    tick();
    frame_end_in = 1'b0;
    exp_gate = 1'b0;
    exp_tab  = 1'b1;
    tick();
    exp_tab = 1'b0;
  endtask

  // clusterer answers after w cycles in WAIT_DIV; model applies the iteration rules
  task automatic km_return(input int ax, input int ay, input int bx, input int by,
                           input int cx, input int cy, input int w);
    int nx [3];
    int ny [3];
    bit all_settled;
    nx = '{ax, bx, cx};
    ny = '{ay, by, cy};
    repeat (w) tick();
    km_valid_in = 1'b1;
    km_a_x_in = 11'(ax); km_a_y_in = 10'(ay);
    km_b_x_in = 11'(bx); km_b_y_in = 10'(by);
    km_c_x_in = 11'(cx); km_c_y_in = 10'(cy);
    tick();
    km_valid_in = 1'b0;
    km_a_x_in = 11'd0; km_b_x_in = 11'd0; km_c_x_in = 11'd0;
    km_a_y_in = 10'd0; km_b_y_in = 10'd0; km_c_y_in = 10'd0;
    tick();
    all_settled = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (mdist(nx[i], ny[i], exp_x[i], exp_y[i]) > 2) all_settled = 1'b0;
      exp_x[i] = nx[i];
      exp_y[i] = ny[i];
    end
    exp_iter++;
    if (all_settled || exp_iter == 8) begin
      exp_conv = all_settled;
      exp_rv   = 1'b1;
      tick();
      exp_rv   = 1'b0;
      exp_busy = 1'b0;
    end
  endtask

  initial begin
    model_reset();
    repeat (2) tick();
    check("reset_iter", int'(iter_out), 0);
    check("reset_cent_c_x", int'(cent_c_x_out), 1120);
    check("reset_busy", int'(busy_out), 0);
    check("model_dist_a", mdist(162, 361, 160, 360), 3);
    check("model_dist_c", mdist(1119, 360, 1120, 360), 1);
    rst_n_in = 1'b1;
    chk_en   = 1'b1;
    tick();

    // first iteration: d = 3,3,1 -> not converged, back to WAIT_FRAME
    do_start();
    do_frame();
    km_return(162, 361, 641, 358, 1119, 360, 2);
    check("t1_iter", int'(iter_out), 1);
    check("t1_cent_b_y", int'(cent_b_y_out), 358);
    check("t1_conv", int'(converged_out), 0);

    // ignored events: frame_end in WAIT_FRAME, start while busy, frame_start in ACCUM
    frame_end_in = 1'b1; tick(); frame_end_in = 1'b0;
    start_in = 1'b1; tick(); start_in = 1'b0;
    check("t_ign_iter", int'(iter_out), 1);
    frame_start_in = 1'b1; tick(); frame_start_in = 1'b0;
    exp_gate = 1'b1;
    frame_start_in = 1'b1; tick(); frame_start_in = 1'b0;
    start_in = 1'b1; tick(); start_in = 1'b0;
    frame_end_in = 1'b1; tick(); frame_end_in = 1'b0;
    exp_gate = 1'b0; exp_tab = 1'b1;
    tick();
    exp_tab = 1'b0;
    // unchanged result -> converged, iteration 2
    km_return(162, 361, 641, 358, 1119, 360, 0);
    check("t_ign_conv", int'(converged_out), 1);

    // fresh run, unchanged centroids -> converged after one iteration
    tick();
    do_start();
    do_frame();
    km_return(160, 360, 640, 360, 1120, 360, 5);
    check("t2_iter", int'(iter_out), 1);
    check("t2_conv", int'(converged_out), 1);

    // centroids always move by 10 -> stops at MAX_ITER unconverged
    do_start();
    for (int k = 1; k <= 8; k++) begin
      do_frame();
      km_return(160 + 10 * k, 360, 640 + 10 * k, 360, 1120 - 10 * k, 360, 1);
    end
    check("t3_iter", int'(iter_out), 8);
    check("t3_conv", int'(converged_out), 0);
    check("t3_cent_a_x", int'(cent_a_x_out), 240);

    // result on the final allowed WAIT_DIV cycle is still taken
    do_start();
    do_frame();
    km_return(170, 360, 640, 360, 1120, 360, 63);
    check("t4_tmo", int'(timeout_out), 0);
    check("t4_cent_a_x", int'(cent_a_x_out), 170);

    // km_valid withheld -> timeout after 64 WAIT_DIV cycles
    // (still in WAIT_FRAME from above; abort back to IDLE first)
    abort_in = 1'b1; tick(); abort_in = 1'b0;
    exp_busy = 1'b0;
    do_start();
    do_frame();
    repeat (63) tick();
    check("t5_tmo_early", int'(timeout_out), 0);
    tick();
    exp_tmo = 1'b1;
    exp_rv  = 1'b1;
    check("t5_tmo", int'(timeout_out), 1);
    check("t5_cent_b_x", int'(cent_b_x_out), 640);
    tick();
    exp_rv   = 1'b0;
    exp_busy = 1'b0;

    // abort during ACCUM
    do_start();
    frame_start_in = 1'b1; tick(); frame_start_in = 1'b0;
    exp_gate = 1'b1;
    tick();
    abort_in = 1'b1; tick(); abort_in = 1'b0;
    exp_gate = 1'b0;
    exp_busy = 1'b0;
    check("t6_gate", int'(pixel_gate_out), 0);
    repeat (3) tick();

    // reset pulsed in WAIT_DIV after centroids have moved
    do_start();
    do_frame();
    km_return(200, 300, 600, 300, 1000, 300, 0);
    do_frame();
    tick();
    #1;
    rst_n_in = 1'b0;
    #1;
    model_reset();
    check("t7_busy", int'(busy_out), 0);
    check("t7_iter", int'(iter_out), 0);
    check("t7_cent_a_x", int'(cent_a_x_out), 160);
    check("t7_cent_c_y", int'(cent_c_y_out), 360);
    tick();
    rst_n_in = 1'b1;
    repeat (3) tick();

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/k_means_scheduler.md
K_MEANS_SCHEDULER -- requirements
Module: k_means_scheduler

Interface
REQ-001 SHALL have parameter MAX_ITER, default 8: maximum refinement iterations per run (1..255).
REQ-002 SHALL have parameter CONV_THRESH, default 2: per-centroid Manhattan move at or below which that centroid is settled.
REQ-003 SHALL have parameter DIV_TIMEOUT, default 64: cycles allowed from tabulate pulse to km_valid_in.
REQ-004 SHALL have parameter CONTINUOUS, default 0: 1 = restart from current centroids after DONE.
REQ-005 SHALL have parameters SEED_A/B/C_X (11b) and SEED_A/B/C_Y (10b), defaults (160,360), (640,360), (1120,360).
REQ-006 SHALL have port clk_in  input  1  the single clock; one clock, all logic on rising edge.
REQ-007 SHALL have port rst_n_in  input  1  reset, asynchronous and active-low.
REQ-008 SHALL have port start_in  input  1  one-cycle pulse; begins a run.
REQ-009 SHALL have port abort_in  input  1  one-cycle pulse; ends a run immediately.
REQ-010 SHALL have ports frame_start_in and frame_end_in  input  1 each  one-cycle frame boundary strobes.
REQ-011 SHALL have port pixel_gate_out  output  1  qualifier ANDed externally with the pixel valid feeding the clusterer.
REQ-012 SHALL have port tabulate_out  output  1  one-cycle pulse that starts the clusterer's dividers.
REQ-013 SHALL have port km_valid_in  input  1  clusterer results ready.
REQ-014 SHALL have ports km_a/b/c_x_in  input  11 each, and km_a/b/c_y_in  input  10 each: new centroids from the clusterer.
REQ-015 SHALL have ports cent_a/b/c_x_out  output  11 each, and cent_a/b/c_y_out  output  10 each: current centroids driven to the clusterer.
REQ-016 SHALL have port iter_out  output  8  completed iterations in the current run.
REQ-017 SHALL have ports busy_out, result_valid_out, converged_out, timeout_out  output  1 each.

Function
REQ-018 SHALL implement states IDLE, WAIT_FRAME, ACCUM, TABULATE, WAIT_DIV, UPDATE, DONE.
REQ-019 SHALL, in IDLE on start_in, load seeds into cent_*, clear iter_out, converged_out and timeout_out, and go to WAIT_FRAME.
REQ-020 SHALL, in WAIT_FRAME, go to ACCUM on frame_start_in; frame_end_in is ignored in WAIT_FRAME.
REQ-021 SHALL hold pixel_gate_out high only while in ACCUM, as a registered output asserted the cycle after frame_start_in.
REQ-022 SHALL, in ACCUM on frame_end_in, deassert the gate and go to TABULATE; frame_start_in is ignored in ACCUM.
REQ-023 SHALL assert tabulate_out for exactly the one cycle spent in TABULATE, then go to WAIT_DIV.
REQ-024 SHALL, in WAIT_DIV, capture all six km_* inputs on the first cycle km_valid_in is high and go to UPDATE.
REQ-025 SHALL, if km_valid_in is not seen within DIV_TIMEOUT cycles of entering WAIT_DIV, set timeout_out, keep cent_* unchanged, and go to DONE with converged_out=0.
REQ-026 SHALL, in UPDATE, compute d = |dx|+|dy| (12-bit, unsigned, no overflow) between captured and current positions for each centroid, write the captured values to cent_*, and increment iter_out.
REQ-027 SHALL set converged_out and go to DONE if all three d <= CONV_THRESH.
REQ-028 SHALL otherwise go to DONE when the incremented iter equals MAX_ITER, else return to WAIT_FRAME.
REQ-029 SHALL pulse result_valid_out for one cycle in DONE, then go to IDLE (CONTINUOUS=0) or WAIT_FRAME with iter cleared and cent_* retained (CONTINUOUS=1).
REQ-030 SHALL hold cent_* constant in every state except UPDATE and the IDLE seed load.
REQ-031 SHALL hold busy_out high in every state except IDLE.
REQ-032 SHALL ignore start_in when not in IDLE.
REQ-033 SHALL, on abort_in in any non-IDLE state, go to IDLE next cycle with gate and tabulate low, cent_* retained and no result_valid_out; abort_in wins over any simultaneous event.
REQ-034 SHALL give km_valid_in priority over timeout expiry when both occur in the same cycle.

Reset
REQ-035 SHALL, while rst_n_in is low, asynchronously force state IDLE, cent_* to the seeds, iter_out 0 and all 1-bit outputs 0; a reset mid-run discards the run.

Structure
REQ-036 SHALL take the state enum, coordinate widths (X_W=11, Y_W=10) and point typedef from shared package k_means_pkg.
REQ-037 SHALL compute distances with one combinational sub-module, km_manhattan, instantiated three times.

Verification
REQ-038 SHALL pass: seeds default, start, one frame, km returns (162,361),(641,358),(1119,360) -> d=3,3,1; iter 1, not converged, back to WAIT_FRAME.
REQ-039 SHALL pass: km returns the current centroids unchanged -> DONE after that iteration, converged_out=1, result_valid_out one cycle, iter_out=1.
REQ-040 SHALL pass: km always moves by 10 -> result_valid_out after iter_out=8, converged_out=0.
REQ-041 SHALL pass: km_valid_in withheld -> timeout_out=1 exactly 64 cycles into WAIT_DIV, cent_* unchanged.
REQ-042 SHALL pass: abort_in during ACCUM -> gate low next cycle, IDLE, no tabulate; then rst_n_in pulsed in WAIT_DIV -> all outputs are at reset values immediately.
REQ-043 SHALL pass: frame_end_in in WAIT_FRAME and frame_start_in in ACCUM -> both ignored; start_in while busy -> ignored.
